cs_window_approx: RTL and testbench

//  Parametrised sliding-window approximation filter; generalises the fixed 9-tap 8-bit CS block.

---
 rtl/cs_window_approx.sv | 80 ++++++++
 tb/tb_cs_window_approx.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/cs_window_approx.sv
// cs_window_approx - sliding-window approximation filter with valid handshake and flush.
// Keeps DEPTH = 2**LOG2M+1 samples and emits (sum + DEPTH*Xappr) >> LOG2M or Xappr.
module cs_window_approx #(
   parameter int W     = 8,
   parameter int LOG2M = 3
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         flush,
   input  logic         mode,
   input  logic         in_valid,
   input  logic [W-1:0] X,
   output logic         out_valid,
   output logic [W+1:0] Y
);
   localparam int DEPTH = (2 ** LOG2M) + 1;
   localparam int SW    = W + LOG2M + 1;
   localparam int CW    = LOG2M + 2;

   typedef enum logic {S_FILL, S_RUN} state_t;

   state_t         state_q;
   logic [W-1:0]   win_q [DEPTH];
   logic [SW-1:0]  sum_q;
   logic [SW-1:0]  sum_d;
   logic [CW-1:0]  cnt_q;
   logic           pend_q;
   logic [W-1:0]   xappr;
   logic [W+1:0]   y_smooth;

   // Largest tap whose DEPTH-multiple does not exceed the sum, i.e. not above the mean.
   always_comb begin
      xappr = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if ((SW'(win_q[i]) * SW'(DEPTH)) <= sum_q && win_q[i] >= xappr) begin
            xappr = win_q[i];
         end
      end
   end

   always_comb begin
      sum_d    = sum_q + SW'(X) - SW'(win_q[DEPTH-1]);
      y_smooth = (W+2)'(((SW+1)'(sum_q) + (SW+1)'(xappr) * (SW+1)'(DEPTH)) >> LOG2M);
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         state_q   <= S_FILL;
         sum_q     <= '0;
         cnt_q     <= '0;
         pend_q    <= 1'b0;
         out_valid <= 1'b0;
         Y         <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            win_q[i] <= '0;
         end
      end else begin
         // A result computed from the window settled by the previous accept.
         out_valid <= pend_q;
         if (pend_q) begin
            Y <= mode ? {2'b00, xappr} : y_smooth;
         end
         pend_q <= 1'b0;
         if (in_valid) begin
            win_q[0] <= X;
            for (int i = 1; i < DEPTH; i++) begin
               win_q[i] <= win_q[i-1];
            end
            sum_q <= sum_d;
            if (cnt_q != CW'(DEPTH)) begin
               cnt_q <= cnt_q + CW'(1);
            end
            if (cnt_q == CW'(DEPTH - 1)) begin
               state_q <= S_RUN;
            end
            pend_q <= (state_q == S_RUN) || (cnt_q == CW'(DEPTH - 1));
         end
      end
   end
endmodule

// File: tb/tb_cs_window_approx.sv
// tb/tb_cs_window_approx.sv - scoreboard bench for cs_window_approx against a queue-based window model.
module tb_cs_window_approx;
   localparam int DEPTH = 9;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       flush = 1'b0;
   logic       mode = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] X = '0;
   logic       out_valid;
   logic [9:0] Y;

   cs_window_approx #(.W(8), .LOG2M(3)) dut (
      .clk(clk), .reset(reset), .flush(flush), .mode(mode),
      .in_valid(in_valid), .X(X), .out_valid(out_valid), .Y(Y)
   );

   always #5 clk = ~clk;

   typedef struct {int due; int ys; int xa;} pend_t;

   int    errors = 0;
   int    checks = 0;
   int    edge_n = 0;
   int    pulses = 0;
   int    last_y = 0;
   int    hold_y = 0;
   bit    mon_on = 0;
   int    win[$];
   pend_t pend[$];
   int    ready[$];

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got=%0d expected=%0d (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Reference: window as a list, mean rule applied directly with plain arithmetic.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         edge_n++;
         if (reset || flush) begin
            win.delete();
            pend.delete();
            ready.delete();
            hold_y = 0;
         end else begin
            if (pend.size() > 0 && pend[0].due == edge_n) begin
               pend_t p;
               p = pend.pop_front();
               ready.push_back(mode ? p.xa : p.ys);
            end
            if (in_valid) begin
               win.push_front(int'(X));
               if (win.size() > DEPTH) void'(win.pop_back());
               if (win.size() == DEPTH) begin
                  int s, xa;
                  pend_t p;
                  s = 0;
                  xa = 0;
                  foreach (win[i]) s += win[i];
                  foreach (win[i]) if (win[i] * DEPTH <= s && win[i] > xa) xa = win[i];
                  p.due = edge_n + 1;
                  p.xa  = xa;
                  p.ys  = (s + DEPTH * xa) / 8;
                  pend.push_back(p);
               end
            end
         end
      end
   end

   // Monitor: every pulse must match the oldest expected result; no pulse means Y holds.
   initial begin
      forever begin
         @(negedge clk);
         if (mon_on) begin
            if (out_valid) begin
               pulses++;
               last_y = int'(Y);
               if (ready.size() == 0) begin
                  chk("unexpected_pulse", 1, 0);
               end else begin
                  int e;
                  e = ready.pop_front();
                  chk("pulse_y", int'(Y), e);
                  hold_y = e;
               end
            end else begin
               if (ready.size() != 0) begin
                  void'(ready.pop_front());
                  chk("missing_pulse", 0, 1);
               end
               chk("y_hold", int'(Y), hold_y);
            end
         end
      end
   end

   task automatic send(input int x, input logic m);
      in_valid = 1'b1;
      X = 8'(x);
      mode = m;
      @(posedge clk);
      #2;
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic clear(input bit use_reset);
      if (use_reset) reset = 1'b1;
      else flush = 1'b1;
      @(posedge clk);
      #2;
      reset = 1'b0;
      flush = 1'b0;
   endtask

   initial begin
      int p0, acc;
      repeat (2) @(posedge clk);
      #2;
      reset = 1'b0;
      @(negedge clk);
      chk("reset_out_valid", int'(out_valid), 0);
      chk("reset_y", int'(Y), 0);
      mon_on = 1;

      // 1: constant 10
      p0 = pulses;
      for (int i = 0; i < 8; i++) send(10, 1'b0);
      idle(2);
      chk("t1_no_early_pulse", pulses - p0, 0);
      send(10, 1'b0);
      idle(2);
      chk("t1_pulses", pulses - p0, 1);
      chk("t1_y", last_y, 22);

      // 2: ramp, slide, then Xappr mode
      clear(0);
      for (int i = 1; i <= 9; i++) send(i, 1'b0);
      idle(2);
      chk("t2_ramp_y", last_y, 11);
      send(10, 1'b0);
      idle(2);
      chk("t2_slide_y", last_y, 13);
      p0 = pulses;
      mode = 1'b1;
      idle(3);
      chk("t2_mode_only_no_pulse", pulses - p0, 0);
      clear(0);
      for (int i = 1; i <= 9; i++) send(i, 1'b0);
      send(10, 1'b1);
      idle(2);
      chk("t2_xappr_y", last_y, 6);

      // 3: full scale
      clear(0);
      for (int i = 0; i < 9; i++) send(255, 1'b0);
      idle(2);
      chk("t3_full_y", last_y, 573);

      // 4: ramp with a gap
      clear(0);
      p0 = pulses;
      for (int i = 1; i <= 4; i++) send(i, 1'b0);
      idle(3);
      for (int i = 5; i <= 9; i++) send(i, 1'b0);
      idle(2);
      chk("t4_pulses", pulses - p0, 1);
      chk("t4_y", last_y, 11);

      // 5: partial fill then flush / reset
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < 8; i++) send(7 + i, 1'b0);
         clear(r[0]);
         @(negedge clk);
         chk(r ? "t5_reset_y0" : "t5_flush_y0", int'(Y), 0);
         p0 = pulses;
         for (int i = 0; i < 8; i++) send(20, 1'b0);
         idle(2);
         chk("t5_no_early_pulse", pulses - p0, 0);
         send(20, 1'b0);
         idle(2);
         chk("t5_pulses", pulses - p0, 1);
         chk("t5_y", last_y, 45);
      end

      // flush arriving while a result is pending must discard it
      for (int i = 0; i < 9; i++) send(30, 1'b0);
      clear(0);
      @(negedge clk);
      chk("pending_discard_y", int'(Y), 0);
      chk("pending_discard_valid", int'(out_valid), 0);

      // 6: random stream
      clear(0);
      p0 = pulses;
      acc = 0;
      for (int n = 0; n < 2000; n++) begin
         send(int'($urandom_range(0, 255)), 1'(($urandom_range(0, 3) == 0)));
         acc++;
         if ($urandom_range(0, 2) == 0) begin
            mode = 1'($urandom_range(0, 1));
            idle(int'($urandom_range(1, 3)));
         end
      end
      idle(3);
      chk("t6_pulse_count", pulses - p0, acc - 8);
      chk("leftover_expected", ready.size() + pend.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
